// File: rtl/cmsa_sequencer.sv
// cmsa_sequencer: IDLE -> LOAD -> COMPUTE -> DRAIN phase sequencer for a whole
// ARRAY_ROWS x ARRAY_COLS CMSA systolic array. It runs one pass per tile and
// repeats for num_tiles tiles. It drives the per-row weight direction and the
// per-column skewed compute window, and provides a start/busy/done handshake,
// abort, and configuration-error reporting.
// Every output is a flop. Each output's next value is decoded from the next
// state, so an output changes on the same edge as the state it reflects.
module cmsa_sequencer #(
    parameter int ARRAY_ROWS = 16,
    parameter int ARRAY_COLS = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [2:0]            kernel_size,
    input  logic [7:0]            num_channels,
    input  logic [7:0]            num_tiles,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [1:0]            phase,
    output logic                  weight_load_en,
    output logic [ARRAY_ROWS-1:0] row_from_down,
    output logic [ARRAY_COLS-1:0] col_valid,
    output logic [ARRAY_COLS-1:0] en_left_a,
    output logic [ARRAY_COLS-1:0] en_left_b,
    output logic                  en_op_out,
    output logic [7:0]            tile_idx
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    // In split mode the upper half of the rows takes its weights from below.
    localparam logic [ARRAY_ROWS-1:0] ROW_UPPER_MASK =
        {{(ARRAY_ROWS/2){1'b1}}, {(ARRAY_ROWS/2){1'b0}}};
    // Column 0 has no B delay register; columns 0 and 1 have no A delay register.
    localparam logic [ARRAY_COLS-1:0] EN_B_MASK = {{(ARRAY_COLS-1){1'b1}}, 1'b0};
    localparam logic [ARRAY_COLS-1:0] EN_A_MASK = {{(ARRAY_COLS-2){1'b1}}, 2'b00};
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      LOAD_LEN_FULL  = CNT_W'(ARRAY_ROWS);
    localparam logic [CNT_W-1:0]      LOAD_LEN_SPLIT = CNT_W'(ARRAY_ROWS / 2);
    localparam logic [CNT_W-1:0]      DRAIN_LEN      = CNT_W'(ARRAY_COLS);

    // Compute length N = K*K*C, evaluated at counter width.
    function automatic logic [CNT_W-1:0] compute_len(input logic [2:0] k,
                                                     input logic [7:0] c);
        logic [CNT_W-1:0] k_w;
        k_w = CNT_W'(k);
        return k_w * k_w * CNT_W'(c);
    endfunction

    // Registered state and configuration.
    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  mode_r;
    logic [CNT_W-1:0]      n_r;
    logic [7:0]            tiles_r;
    logic [7:0]            tile_idx_r;
    logic                  done_r;
    logic                  cfg_err_r;
    logic                  busy_r;
    logic [1:0]            phase_r;
    logic                  weight_load_en_r;
    logic [ARRAY_ROWS-1:0] row_from_down_r;
    logic [ARRAY_COLS-1:0] col_valid_r;
    logic [ARRAY_COLS-1:0] en_left_a_r;
    logic [ARRAY_COLS-1:0] en_left_b_r;
    logic                  en_op_out_r;

    // Next-state and control signals.
    state_t                state_n_s;
    logic [CNT_W-1:0]      cnt_n_s;
    logic [CNT_W-1:0]      len_s;
    logic                  last_s;
    logic                  last_tile_s;
    logic                  cfg_bad_s;
    logic                  accept_s;
    logic                  clear_cv_s;
    logic [7:0]            tile_n_s;
    logic                  done_n_s;
    logic                  cfg_err_n_s;
    logic                  mode_n_s;
    logic [ARRAY_COLS-1:0] col_valid_n_s;

    assign last_s      = (cnt_r == (len_s - CNT_ONE));
    assign last_tile_s = (tile_idx_r == (tiles_r - 8'd1));
    assign cfg_bad_s   = (kernel_size == 3'd0) || (num_channels == 8'd0);

    // Select the length of the phase that is currently running.
    always_comb begin
        case (state_r)
            S_LOAD:    len_s = mode_r ? LOAD_LEN_SPLIT : LOAD_LEN_FULL;
            S_COMPUTE: len_s = n_r;
            S_DRAIN:   len_s = DRAIN_LEN;
            default:   len_s = CNT_ONE;
        endcase
    end

    // Next-state logic, tile sequencing, done/cfg_err pulses; abort overrides.
    always_comb begin
        state_n_s   = state_r;
        tile_n_s    = tile_idx_r;
        done_n_s    = 1'b0;
        cfg_err_n_s = 1'b0;
        accept_s    = 1'b0;
        clear_cv_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad_s) begin
                        done_n_s    = 1'b1;
                        cfg_err_n_s = 1'b1;
                    end else begin
                        accept_s  = 1'b1;
                        state_n_s = S_LOAD;
                        tile_n_s  = 8'd0;
                    end
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (last_s) begin
                    state_n_s = S_COMPUTE;
                end else begin
                    state_n_s = S_LOAD;
                end
            end
            S_COMPUTE: begin
                if (last_s) begin
                    state_n_s = S_DRAIN;
                end else begin
                    state_n_s = S_COMPUTE;
                end
            end
            S_DRAIN: begin
                if (last_s) begin
                    if (last_tile_s) begin
                        state_n_s = S_IDLE;
                        tile_n_s  = 8'd0;
                        done_n_s  = 1'b1;
                    end else begin
                        state_n_s = S_LOAD;
                        tile_n_s  = tile_idx_r + 8'd1;
                    end
                end else begin
                    state_n_s = S_DRAIN;
                end
            end
            default: begin
                state_n_s = S_IDLE;
                tile_n_s  = 8'd0;
            end
        endcase
        if (abort && (state_r != S_IDLE)) begin
            state_n_s  = S_IDLE;
            tile_n_s   = 8'd0;
            done_n_s   = 1'b0;
            clear_cv_s = 1'b1;
        end else begin
            clear_cv_s = 1'b0;
        end
    end

    // Phase counter restart, effective mode, and the column-window shift.
    always_comb begin
        if ((state_n_s != state_r) || (state_n_s == S_IDLE)) begin
            cnt_n_s = CNT_ZERO;
        end else begin
            cnt_n_s = cnt_r + CNT_ONE;
        end
        if (accept_s) begin
            mode_n_s = mode;
        end else begin
            mode_n_s = mode_r;
        end
        if (clear_cv_s) begin
            col_valid_n_s = {ARRAY_COLS{1'b0}};
        end else begin
            col_valid_n_s = {col_valid_r[ARRAY_COLS-2:0], (state_n_s == S_COMPUTE)};
        end
    end

    // Latch the run configuration when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r  <= 1'b0;
            n_r     <= CNT_ZERO;
            tiles_r <= 8'd0;
        end else if (accept_s) begin
            mode_r  <= mode;
            n_r     <= compute_len(kernel_size, num_channels);
            tiles_r <= (num_tiles == 8'd0) ? 8'd1 : num_tiles;
        end
    end

    // State register, phase counter and tile index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= CNT_ZERO;
            tile_idx_r <= 8'd0;
        end else begin
            state_r    <= state_n_s;
            cnt_r      <= cnt_n_s;
            tile_idx_r <= tile_n_s;
        end
    end

    // Output registers, loaded from next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r           <= 1'b0;
            cfg_err_r        <= 1'b0;
            busy_r           <= 1'b0;
            phase_r          <= 2'd0;
            weight_load_en_r <= 1'b0;
            row_from_down_r  <= {ARRAY_ROWS{1'b0}};
            col_valid_r      <= {ARRAY_COLS{1'b0}};
            en_left_a_r      <= {ARRAY_COLS{1'b0}};
            en_left_b_r      <= {ARRAY_COLS{1'b0}};
            en_op_out_r      <= 1'b0;
        end else begin
            done_r           <= done_n_s;
            cfg_err_r        <= cfg_err_n_s;
            busy_r           <= (state_n_s != S_IDLE);
            phase_r          <= state_n_s;
            weight_load_en_r <= (state_n_s == S_LOAD);
            row_from_down_r  <= ((state_n_s == S_LOAD) && mode_n_s) ? ROW_UPPER_MASK
                                                                    : {ARRAY_ROWS{1'b0}};
            col_valid_r      <= col_valid_n_s;
            en_left_a_r      <= col_valid_n_s & EN_A_MASK;
            en_left_b_r      <= col_valid_n_s & EN_B_MASK;
            en_op_out_r      <= (|col_valid_n_s) || (state_n_s == S_DRAIN);
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign cfg_err        = cfg_err_r;
    assign phase          = phase_r;
    assign weight_load_en = weight_load_en_r;
    assign row_from_down  = row_from_down_r;
    assign col_valid      = col_valid_r;
    assign en_left_a      = en_left_a_r;
    assign en_left_b      = en_left_b_r;
    assign en_op_out      = en_op_out_r;
    assign tile_idx       = tile_idx_r;

endmodule

// File: tb/tb_cmsa_sequencer.sv
// Directed testbench for cmsa_sequencer with a 4x4 array.
// Cycle k is the interval after clock edge k. An input driven during cycle k
// is sampled at edge k+1. Outputs are sampled 1 ns after each rising edge.
module tb_cmsa_sequencer;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            mode = 1'b0;
    logic [2:0]      kernel_size = 3'd3;
    logic [7:0]      num_channels = 8'd1;
    logic [7:0]      num_tiles = 8'd1;
    logic            busy;
    logic            done;
    logic            cfg_err;
    logic [1:0]      phase;
    logic            weight_load_en;
    logic [ROWS-1:0] row_from_down;
    logic [COLS-1:0] col_valid;
    logic [COLS-1:0] en_left_a;
    logic [COLS-1:0] en_left_b;
    logic            en_op_out;
    logic [7:0]      tile_idx;

    int tests = 0;
    int fails = 0;

    cmsa_sequencer #(.ARRAY_ROWS(ROWS), .ARRAY_COLS(COLS), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .kernel_size(kernel_size), .num_channels(num_channels), .num_tiles(num_tiles),
        .busy(busy), .done(done), .cfg_err(cfg_err), .phase(phase),
        .weight_load_en(weight_load_en), .row_from_down(row_from_down),
        .col_valid(col_valid), .en_left_a(en_left_a), .en_left_b(en_left_b),
        .en_op_out(en_op_out), .tile_idx(tile_idx)
    );

    always #5 clk = ~clk;

    // Reference model: a run started in cycle 0 with load length l, compute
    // length n and t tiles. The drain length is COLS (4) cycles.
    function automatic logic [1:0] m_phase(input int k, input int l, input int n, input int t);
        int p;
        int j;
        p = l + n + COLS;
        if (k < 1 || k > t * p) return 2'd0;
        j = (k - 1) % p;
        if (j < l) return 2'd1;
        if (j < l + n) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] m_cv(input int k, input int l, input int n, input int t);
        logic [3:0] v;
        int p;
        int j;
        v = 4'b0000;
        p = l + n + COLS;
        if (k >= 1 && k <= t * p) begin
            j = (k - 1) % p;
            for (int c = 0; c < COLS; c++) begin
                if (j >= l + c && j <= l + n - 1 + c) v[c] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic m_done(input int k, input int l, input int n, input int t);
        return (k == t * (l + n + COLS) + 1);
    endfunction

    function automatic logic [7:0] m_tile(input int k, input int l, input int n, input int t);
        int p;
        p = l + n + COLS;
        if (k < 1 || k > t * p) return 8'd0;
        return 8'((k - 1) / p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        tests++; if (phase !== 2'd0) begin fails++; $display("FAIL reset.phase got %0d expected 0", phase); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset.busy got %b expected 0", busy); end
        tests++; if (done !== 1'b0 || cfg_err !== 1'b0) begin fails++; $display("FAIL reset.done_cfg_err got %b%b expected 00", done, cfg_err); end
        tests++; if (col_valid !== 4'b0000 || en_op_out !== 1'b0) begin fails++; $display("FAIL reset.col_valid got %b/%b expected 0000/0", col_valid, en_op_out); end
        tests++; if (tile_idx !== 8'd0 || weight_load_en !== 1'b0) begin fails++; $display("FAIL reset.tile_wl got %0d/%b expected 0/0", tile_idx, weight_load_en); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_normal();
        logic [1:0] ep;
        logic [3:0] ecv;
        mode = 1'b0; kernel_size = 3'd3; num_channels = 8'd1; num_tiles = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        // These changes must be ignored until the next run.
        mode = 1'b1; kernel_size = 3'd1; num_channels = 8'd7; num_tiles = 8'd5;
        for (int k = 1; k <= 20; k++) begin
            ep = m_phase(k, 4, 9, 1);
            ecv = m_cv(k, 4, 9, 1);
            tests++; if (phase !== ep) begin fails++; $display("FAIL normal.phase cycle %0d got %0d expected %0d", k, phase, ep); end
            tests++; if (busy !== (ep != 2'd0)) begin fails++; $display("FAIL normal.busy cycle %0d got %b", k, busy); end
            tests++; if (done !== m_done(k, 4, 9, 1)) begin fails++; $display("FAIL normal.done cycle %0d got %b", k, done); end
            tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL normal.cfg_err cycle %0d got %b expected 0", k, cfg_err); end
            tests++; if (weight_load_en !== (ep == 2'd1)) begin fails++; $display("FAIL normal.weight_load_en cycle %0d got %b", k, weight_load_en); end
            tests++; if (row_from_down !== 4'b0000) begin fails++; $display("FAIL normal.row_from_down cycle %0d got %b expected 0000", k, row_from_down); end
            tests++; if (col_valid !== ecv) begin fails++; $display("FAIL normal.col_valid cycle %0d got %b expected %b", k, col_valid, ecv); end
            tests++; if (en_left_b !== (ecv & 4'b1110)) begin fails++; $display("FAIL normal.en_left_b cycle %0d got %b expected %b", k, en_left_b, ecv & 4'b1110); end
            tests++; if (en_left_a !== (ecv & 4'b1100)) begin fails++; $display("FAIL normal.en_left_a cycle %0d got %b expected %b", k, en_left_a, ecv & 4'b1100); end
            tests++; if (en_op_out !== ((|ecv) || (ep == 2'd3))) begin fails++; $display("FAIL normal.en_op_out cycle %0d got %b", k, en_op_out); end
            tests++; if (tile_idx !== 8'd0) begin fails++; $display("FAIL normal.tile_idx cycle %0d got %0d expected 0", k, tile_idx); end
            step();
        end
    endtask

    task automatic test_split();
        logic [1:0] ep;
        mode = 1'b1; kernel_size = 3'd3; num_channels = 8'd1; num_tiles = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            ep = m_phase(k, 2, 9, 1);
            tests++; if (phase !== ep) begin fails++; $display("FAIL split.phase cycle %0d got %0d expected %0d", k, phase, ep); end
            tests++; if (row_from_down !== ((ep == 2'd1) ? 4'b1100 : 4'b0000)) begin fails++; $display("FAIL split.row_from_down cycle %0d got %b", k, row_from_down); end
            tests++; if (col_valid !== m_cv(k, 2, 9, 1)) begin fails++; $display("FAIL split.col_valid cycle %0d got %b expected %b", k, col_valid, m_cv(k, 2, 9, 1)); end
            tests++; if (done !== m_done(k, 2, 9, 1)) begin fails++; $display("FAIL split.done cycle %0d got %b", k, done); end
            step();
        end
    endtask

    task automatic test_multi_tile();
        logic [1:0] ep;
        mode = 1'b0; kernel_size = 3'd3; num_channels = 8'd1; num_tiles = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            ep = m_phase(k, 4, 9, 2);
            tests++; if (phase !== ep) begin fails++; $display("FAIL multi.phase cycle %0d got %0d expected %0d", k, phase, ep); end
            tests++; if (done !== m_done(k, 4, 9, 2)) begin fails++; $display("FAIL multi.done cycle %0d got %b", k, done); end
            tests++; if (col_valid !== m_cv(k, 4, 9, 2)) begin fails++; $display("FAIL multi.col_valid cycle %0d got %b expected %b", k, col_valid, m_cv(k, 4, 9, 2)); end
            if (ep != 2'd0) begin
                tests++; if (tile_idx !== m_tile(k, 4, 9, 2)) begin fails++; $display("FAIL multi.tile_idx cycle %0d got %0d expected %0d", k, tile_idx, m_tile(k, 4, 9, 2)); end
            end
            step();
        end
        // A tile count of zero runs a single tile.
        num_tiles = 8'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tests++; if (phase !== m_phase(k, 4, 9, 1)) begin fails++; $display("FAIL tiles0.phase cycle %0d got %0d expected %0d", k, phase, m_phase(k, 4, 9, 1)); end
            tests++; if (done !== m_done(k, 4, 9, 1)) begin fails++; $display("FAIL tiles0.done cycle %0d got %b", k, done); end
            step();
        end
    endtask

    task automatic test_cfg_err();
        for (int v = 0; v < 2; v++) begin
            mode = 1'b0; num_tiles = 8'd1;
            kernel_size  = (v == 0) ? 3'd0 : 3'd3;
            num_channels = (v == 0) ? 8'd1 : 8'd0;
            start = 1'b1;
            step();
            start = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                tests++; if (busy !== 1'b0 || phase !== 2'd0) begin fails++; $display("FAIL cfg_err.busy variant %0d cycle %0d got %b/%0d expected 0/0", v, k, busy, phase); end
                tests++; if (done !== (k == 1)) begin fails++; $display("FAIL cfg_err.done variant %0d cycle %0d got %b", v, k, done); end
                tests++; if (cfg_err !== (k == 1)) begin fails++; $display("FAIL cfg_err.flag variant %0d cycle %0d got %b", v, k, cfg_err); end
                tests++; if (weight_load_en !== 1'b0 || col_valid !== 4'b0000 || en_op_out !== 1'b0) begin fails++; $display("FAIL cfg_err.enables variant %0d cycle %0d got %b/%b/%b expected all 0", v, k, weight_load_en, col_valid, en_op_out); end
                step();
            end
        end
    endtask

    task automatic test_abort();
        int kr;
        mode = 1'b0; kernel_size = 3'd3; num_channels = 8'd1; num_tiles = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            kr = (k <= 7) ? k : ((k >= 10) ? k - 9 : 0);
            tests++; if (phase !== m_phase(kr, 4, 9, 1)) begin fails++; $display("FAIL abort.phase cycle %0d got %0d expected %0d", k, phase, m_phase(kr, 4, 9, 1)); end
            tests++; if (col_valid !== m_cv(kr, 4, 9, 1)) begin fails++; $display("FAIL abort.col_valid cycle %0d got %b expected %b", k, col_valid, m_cv(kr, 4, 9, 1)); end
            tests++; if (done !== m_done(kr, 4, 9, 1)) begin fails++; $display("FAIL abort.done cycle %0d got %b", k, done); end
            abort = (k == 7);
            start = (k == 9);
            step();
        end
        abort = 1'b0; start = 1'b0;
        // Abort while idle does nothing.
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++; if (phase !== 2'd0 || done !== 1'b0) begin fails++; $display("FAIL abort.idle got phase %0d done %b expected 0/0", phase, done); end
        // Start and abort together in IDLE: start wins.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        tests++; if (phase !== 2'd1) begin fails++; $display("FAIL abort.start_wins got phase %0d expected 1", phase); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++; if (phase !== 2'd0 || done !== 1'b0 || tile_idx !== 8'd0) begin fails++; $display("FAIL abort.load got phase %0d done %b tile %0d expected 0/0/0", phase, done, tile_idx); end
        step();
    endtask

    task automatic test_ignored_start();
        mode = 1'b0; kernel_size = 3'd3; num_channels = 8'd1; num_tiles = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tests++; if (phase !== m_phase(k, 4, 9, 1)) begin fails++; $display("FAIL ignored_start.phase cycle %0d got %0d expected %0d", k, phase, m_phase(k, 4, 9, 1)); end
            tests++; if (done !== m_done(k, 4, 9, 1)) begin fails++; $display("FAIL ignored_start.done cycle %0d got %b", k, done); end
            start = (k == 3) || (k == 10);
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_midrun();
        mode = 1'b1; kernel_size = 3'd3; num_channels = 8'd1; num_tiles = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 6; k++) step();
        // Cycle 6 of a split run is in COMPUTE.
        tests++; if (phase !== 2'd2 || col_valid === 4'b0000) begin fails++; $display("FAIL reset_mid.pre got phase %0d col_valid %b expected 2/nonzero", phase, col_valid); end
        #2 reset = 1'b1;
        #1;
        tests++; if (phase !== 2'd0 || busy !== 1'b0) begin fails++; $display("FAIL reset_mid.state got phase %0d busy %b expected 0/0", phase, busy); end
        tests++; if (col_valid !== 4'b0000 || en_left_a !== 4'b0000 || en_left_b !== 4'b0000 || en_op_out !== 1'b0) begin fails++; $display("FAIL reset_mid.enables got %b/%b/%b/%b expected all 0", col_valid, en_left_a, en_left_b, en_op_out); end
        tests++; if (weight_load_en !== 1'b0 || row_from_down !== 4'b0000 || tile_idx !== 8'd0 || done !== 1'b0 || cfg_err !== 1'b0) begin fails++; $display("FAIL reset_mid.misc got wl %b rfd %b tile %0d done %b cfg_err %b expected all 0", weight_load_en, row_from_down, tile_idx, done, cfg_err); end
        step();
        reset = 1'b0;
        step();
        tests++; if (phase !== 2'd0 || done !== 1'b0) begin fails++; $display("FAIL reset_mid.post got phase %0d done %b expected 0/0", phase, done); end
    endtask

    task automatic test_back_to_back();
        int kr;
        mode = 1'b0; kernel_size = 3'd3; num_channels = 8'd1; num_tiles = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            kr = (k <= 18) ? k : k - 18;
            tests++; if (phase !== m_phase(kr, 4, 9, 1)) begin fails++; $display("FAIL b2b.phase cycle %0d got %0d expected %0d", k, phase, m_phase(kr, 4, 9, 1)); end
            tests++; if (done !== m_done(kr, 4, 9, 1)) begin fails++; $display("FAIL b2b.done cycle %0d got %b", k, done); end
            tests++; if (col_valid !== m_cv(kr, 4, 9, 1)) begin fails++; $display("FAIL b2b.col_valid cycle %0d got %b expected %b", k, col_valid, m_cv(kr, 4, 9, 1)); end
            start = (k == 18);
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_split();
        test_multi_tile();
        test_cfg_err();
        test_abort();
        test_ignored_start();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmsa_sequencer.md
# cmsa_sequencer

Parametrised phase sequencer for the CMSA systolic array in the GAN accelerator, replacing the per-PE controller. It runs a four-phase state machine, IDLE → LOAD → COMPUTE → DRAIN, once per tile, for a whole ARRAY_ROWS × ARRAY_COLS array. It drives per-row weight-direction and per-column skewed enable vectors. It adds a start/busy/done handshake, multi-tile repeat, abort, and configuration-error reporting.

## Interface
- ARRAY_ROWS, 16: PE rows; must be even.
- ARRAY_COLS, 16: PE columns; must be ≥ 3.
- CNT_W, 16: width of the phase counter and of the cycle-count product.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; accepted only in IDLE.
- abort  in  1  synchronous; returns to IDLE next cycle.
- mode  in  1  0 = normal, 1 = split.
- kernel_size  in  3  K.
- num_channels  in  8  C.
- num_tiles  in  8  tiles per run; 0 is treated as 1.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- cfg_err  out  1  valid together with done; set when K = 0 or C = 0.
- phase  out  2  IDLE = 0, LOAD = 1, COMPUTE = 2, DRAIN = 3.
- weight_load_en  out  1  high during LOAD.
- row_from_down  out  ARRAY_ROWS  per row: 1 selects the weight from below.
- col_valid  out  ARRAY_COLS  skewed compute window per column.
- en_left_a, en_left_b  out  ARRAY_COLS  input-delay register enables.
- en_op_out  out  1  MAC output register enable.
- tile_idx  out  8  index of the current tile.

## Operation
- **Config latch:** mode, K, C and num_tiles are latched when start is accepted. Later input changes are ignored until the next run.
- **Compute length:** N = K·K·C, computed at CNT_W width (maximum 49·255 = 12495).
- **Phase counter:** cleared on every state entry.
- **Configuration error:** if start arrives with K = 0 or C = 0, the block stays in IDLE. done and cfg_err pulse on the next cycle.
- **LOAD:**
  - Length is L = ARRAY_ROWS cycles in normal mode, ARRAY_ROWS/2 in split mode.
  - weight_load_en = 1.
  - row_from_down[r] = mode && (r ≥ ARRAY_ROWS/2) during LOAD; 0 otherwise.
- **COMPUTE:**
  - Lasts N cycles.
  - col_valid[0] = (state == COMPUTE).
  - col_valid[c] = col_valid[c-1] registered one cycle (a shift register that also clocks during DRAIN and IDLE).
- **Enables:**
  - en_left_b[c] = col_valid[c] && c ≥ 1.
  - en_left_a[c] = col_valid[c] && c ≥ 2.
  - en_op_out = OR of col_valid, or state == DRAIN.
- **DRAIN:**
  - Lasts ARRAY_COLS cycles.
  - At the end: if tile_idx < tiles−1, increment tile_idx and go to LOAD; otherwise go to IDLE and pulse done.
- **Abort:**
  - From any non-IDLE state, abort forces IDLE on the next edge.
  - col_valid shift register and tile_idx are cleared; done is not pulsed.
  - abort in IDLE has no effect.
- **Start/abort conflicts:** start while busy is ignored. start and abort together in IDLE: start wins.

## Timing
- **Reset values:** state IDLE; every output 0, including col_valid, tile_idx, done and cfg_err. Reset mid-run behaves like abort but takes effect asynchronously.
- **Single tile (start sampled at edge 0):**
  - LOAD occupies cycles 1..L.
  - COMPUTE occupies cycles L+1..L+N.
  - DRAIN occupies cycles L+N+1..L+N+ARRAY_COLS.
  - done is high in cycle L+N+ARRAY_COLS+1, with busy already 0.
- **Multi-tile:** each extra tile adds L+N+ARRAY_COLS cycles with no idle gap between tiles.
- **Column skew:** col_valid[c] is high for exactly N cycles, starting c cycles after COMPUTE begins. The last column's window always ends inside DRAIN.
- **Back-to-back runs:** a start in the done cycle is accepted, so runs may be back-to-back.

## Test plan
- **Normal, single tile:** ROWS = COLS = 4, mode 0, K = 3, C = 1, tiles 1, start at cycle 0 → LOAD cycles 1–4; COMPUTE 5–13; col_valid[3] high cycles 8–16; en_left_a[1] never high; done at cycle 18.
- **Split mode:** same config with mode 1 → LOAD cycles 1–2 with row_from_down = 4'b1100; COMPUTE 3–11; done at cycle 16.
- **Multi-tile:** tiles = 2, mode 0 → tile_idx becomes 1 at cycle 18, second LOAD runs 18–21, done at cycle 35, single pulse.
- **Config error:** K = 0 → busy stays 0; done = cfg_err = 1 at cycle 1; all enables stay 0.
- **Abort:** abort at cycle 7 (mid-COMPUTE) → phase = IDLE at cycle 8, col_valid all 0, no done. A new start at cycle 9 gives done at cycle 27.
- **Reset and ignored start:** reset asserted at cycle 6 → all outputs 0 immediately. start pulses while busy (cycle 3) are ignored and the run timing is unchanged.
